// File: rtl/decode_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : decode_hazard_unit
// Brief    : Decode-side pipeline front end. Latches PC/IR from fetch into
//            the decode/execute latch, tracks in-flight writers per register
//            with a 2-bit scoreboard, and raises branch and dependency stalls
//            toward fetch. All state changes on the falling clock edge.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   I_CLOCK             in   1  pipeline clock (state updates on negedge)
//   I_RESET             in   1  synchronous active-high reset
//   I_LOCK              in   1  pipeline run enable
//   I_PC                in  16  PC presented by fetch
//   I_IR                in  32  instruction presented by fetch
//   I_FE_Valid          in   1  fetch output is a real instruction
//   I_WB_Enable         in   1  a writeback retires this cycle
//   I_WB_RegIdx         in   4  register being retired
//   I_BranchAddrSelect  in   1  branch resolved in memory stage
//   O_LOCK              out  1  registered copy of I_LOCK
//   O_PC                out 16  latched PC to execute
//   O_IR                out 32  latched IR to execute
//   O_DE_Valid          out  1  latched instruction is real
//   O_BranchStallSignal out  1  branch in flight
//   O_DepStallSignal    out  1  register hazard on I_IR (combinational)
// ============================================================================
module decode_hazard_unit #(
    parameter logic [31:0] NOP_IR   = 32'hFF000000,
    parameter logic [3:0]  BR_CLASS = 4'h2,
    parameter logic [3:0]  ST_CLASS = 4'h3
) (
    input  wire logic        I_CLOCK,
    input  wire logic        I_RESET,
    input  wire logic        I_LOCK,
    input  wire logic [15:0] I_PC,
    input  wire logic [31:0] I_IR,
    input  wire logic        I_FE_Valid,
    input  wire logic        I_WB_Enable,
    input  wire logic [3:0]  I_WB_RegIdx,
    input  wire logic        I_BranchAddrSelect,
    output logic             O_LOCK,
    output logic [15:0]      O_PC,
    output logic [31:0]      O_IR,
    output logic             O_DE_Valid,
    output logic             O_BranchStallSignal,
    output logic             O_DepStallSignal
);

    logic [1:0] r_busy [16];
    logic       r_branch_pending;
    logic [1:0] w_busy_nxt [16];

    logic [3:0] w_dr;
    logic [3:0] w_sr1;
    logic [3:0] w_sr2;
    logic       w_sr2_used;
    logic       w_nop;
    logic       w_branch;
    logic       w_store;
    logic       w_writer;
    logic       w_present;
    logic       w_hazard;
    logic       w_accept;
    logic       w_clear;

    assign w_dr       = I_IR[23:20];
    assign w_sr1      = I_IR[19:16];
    assign w_sr2      = I_IR[11:8];
    assign w_sr2_used = ~I_IR[27];

    assign w_nop    = (I_IR[31:24] == NOP_IR[31:24]);
    assign w_branch = ~w_nop & (I_IR[31:28] == BR_CLASS);
    assign w_store  = ~w_nop & (I_IR[31:28] == ST_CLASS);
    assign w_writer = ~w_nop & ~w_branch & ~w_store;

    assign w_present = I_LOCK & I_FE_Valid & ~w_nop;

    // Stall check uses pre-edge counts only; a writeback in the same cycle
    // releases the stall one edge later. A writer is also held off when its
    // destination counter is saturated.
    assign w_hazard = (r_busy[w_sr1] != 2'd0)
                    | (w_sr2_used & (r_busy[w_sr2] != 2'd0))
                    | (w_writer & (r_busy[w_dr] == 2'd3));

    // A pending branch masks the dependency stall so fetch sees one cause.
    assign O_DepStallSignal    = w_present & ~r_branch_pending & w_hazard;
    assign O_BranchStallSignal = r_branch_pending;

    assign w_accept = w_present & ~r_branch_pending & ~w_hazard;

    // Dropping the run enable behaves exactly like reset.
    assign w_clear = I_RESET | ~I_LOCK;

    // Per-register counter update; simultaneous issue and retire cancel out.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            logic l_inc;
            logic l_dec;
            l_inc = w_accept & w_writer & (w_dr == 4'(i));
            l_dec = I_WB_Enable & (I_WB_RegIdx == 4'(i)) & (r_busy[i] != 2'd0);
            w_busy_nxt[i] = r_busy[i];
            if (l_inc && !l_dec) begin
                w_busy_nxt[i] = r_busy[i] + 2'd1;
            end else if (l_dec && !l_inc) begin
                w_busy_nxt[i] = r_busy[i] - 2'd1;
            end
        end
    end

    always_ff @(negedge I_CLOCK) begin
        if (I_RESET) begin
            O_LOCK <= 1'b0;
        end else begin
            O_LOCK <= I_LOCK;
        end
    end

    always_ff @(negedge I_CLOCK) begin
        if (w_clear) begin
            O_PC             <= 16'h0000;
            O_IR             <= NOP_IR;
            O_DE_Valid       <= 1'b0;
            r_branch_pending <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                r_busy[i] <= 2'd0;
            end
        end else begin
            if (w_accept) begin
                O_PC       <= I_PC;
                O_IR       <= I_IR;
                O_DE_Valid <= 1'b1;
            end else begin
                O_IR       <= NOP_IR;
                O_DE_Valid <= 1'b0;
            end

            // Accept cannot occur while pending, so set and clear never race.
            if (w_accept && w_branch) begin
                r_branch_pending <= 1'b1;
            end else if (I_BranchAddrSelect) begin
                r_branch_pending <= 1'b0;
            end

            for (int i = 0; i < 16; i++) begin
                r_busy[i] <= w_busy_nxt[i];
            end
        end
    end

endmodule
`default_nettype wire
